pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for IF/ID/EXE. Generates stall, flush and bubble controls for:
//   - load-use hazards
//   - taken jumps/branches resolved in EXE
//   - multi-cycle MDU ops
//   - memory back-pressure
//   - traps
//  Owns the registered PC redirect to IF and saturating stall/flush perf counters.
// PARAMETERS
//  XLEN         32  datapath/PC width
//  MDU_TIMEOUT  64  max MDU_WAIT cycles before forced abort
//  CNT_W        32  perf counter width
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     reset, asynchronous, active-low
//  id_valid        in   1     valid instr in ID
//  id_rs1          in   5     ID source reg 1
//  id_rs2          in   5     ID source reg 2
//  id_rs1_used     in   1     rs1 read by ID instr
//  id_rs2_used     in   1     rs2 read by ID instr
//  exe_valid       in   1     valid instr in EXE
//  exe_rd          in   5     EXE dest reg
//  exe_rd_wen      in   1     EXE writes rd
//  exe_mem_re      in   1     EXE instr is a load
//  exe_jmp_taken   in   1     EXE jump/branch taken
//  exe_jmp_target  in   XLEN  EXE target PC
//  mdu_start       in   1     EXE issues multi-cycle op
//  mdu_done        in   1     MDU result ready (1-cycle pulse)
//  mem_busy        in   1     MEM stage cannot accept
//  trap_req        in   1     trap/exception request
//  trap_vector     in   XLEN  trap handler PC
//  if_stall        out  1     hold PC and IF/ID reg
//  id_stall        out  1     hold ID/EXE inputs
//  exe_stall       out  1     hold EXE/MEM reg
//  id_flush        out  1     zero IF/ID reg at next edge
//  exe_bubble      out  1     zero ID/EXE reg at next edge
//  mdu_abort       out  1     1-cycle pulse, cancel MDU
//  mdu_timeout     out  1     1-cycle pulse, watchdog fired
//  redirect_valid  out  1     registered PC redirect to IF
//  redirect_pc     out  XLEN  registered redirect target
//  stall_cnt       out  CNT_W cycles with if_stall=1, saturating
//  flush_cnt       out  CNT_W accepted redirects, saturating
// BEHAVIOUR
//  Reset:
//   - All outputs 0, state RUN, counters 0. Reset mid-op aborts any MDU_WAIT silently (no mdu_abort pulse).
//  States:
//   RUN      default
//   REDIRECT 1 cycle after an accepted redirect
//   MDU_WAIT waiting on the MDU
//  Controls (combinational from state and inputs, evaluated in priority order):
//   1. trap_req (any state): id_flush=exe_bubble=1.
//      - At edge: redirect_valid<=1, redirect_pc<=trap_vector, ->REDIRECT.
//      - If in MDU_WAIT: mdu_abort=1 this cycle.
//      - Overrides mem_busy.
//   2. mem_busy: if_stall=id_stall=exe_stall=1.
//      - No jump/MDU/load-use event accepted; EXE re-presents the event.
//      - State held; MDU counter keeps counting.
//   3. RUN & exe_valid & exe_jmp_taken: id_flush=exe_bubble=1.
//      - At edge: redirect_valid<=1, redirect_pc<=exe_jmp_target, ->REDIRECT.
//   4. RUN & exe_valid & mdu_start: at edge ->MDU_WAIT, cnt<=0.
//   5. RUN load-use: exe_valid & exe_mem_re & exe_rd_wen & exe_rd!=0 & id_valid
//      & ((id_rs1_used & id_rs1==exe_rd) | (id_rs2_used & id_rs2==exe_rd)).
//      - if_stall=id_stall=exe_bubble=1 for exactly 1 cycle; no state change.
//  REDIRECT:
//   - redirect_valid=1 for this single cycle.
//   - id_flush=exe_bubble=1 again (kills wrong-path fetch).
//   - Next: RUN.
//  MDU_WAIT:
//   - if_stall=id_stall=exe_stall=1 while !mdu_done.
//   - mdu_done: all stalls 0 that cycle, ->RUN.
//   - cnt==MDU_TIMEOUT-1 without done: mdu_timeout=mdu_abort=1, stalls released, ->RUN.
//  Simultaneous events:
//   - mdu_done & trap_req: trap wins, no abort pulse.
//   - jump & load-use same cycle: jump wins, no stall.
//  Counters:
//   - stall_cnt += if_stall; flush_cnt += 1 per entry to REDIRECT.
//   - Both hold at all-ones.
// TESTING
//  1. lw x5 in EXE, ID reads rs1=x5 -> exactly 1 cycle if_stall=id_stall=exe_bubble=1; x0 dest -> no stall.
//  2. Taken jump to 0x8000_0040 at T -> id_flush at T and T+1; redirect_valid=1 at T+1 only, pc=0x8000_0040.
//  3. mdu_start, mdu_done after 5 cycles -> exe_stall high 5 cycles, low on done cycle; stall_cnt=5.
//  4. mdu_start, no done, MDU_TIMEOUT=8 -> mdu_timeout/mdu_abort pulse in 8th wait cycle, back to RUN.
//  5. mem_busy with jump pending 3 cycles -> no redirect until mem_busy falls, then normal redirect.
//  6. trap_req during MDU_WAIT -> mdu_abort pulse, redirect_pc=trap_vector; rst_n low mid-wait -> all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the IF/ID/EXE datapath (master) and the
// hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             exe_valid;
    logic [4:0]       exe_rd;
    logic             exe_rd_wen;
    logic             exe_mem_re;
    logic             exe_jmp_taken;
    logic [XLEN-1:0]  exe_jmp_target;
    logic             mdu_start;
    logic             mdu_done;
    logic             mem_busy;
    logic             trap_req;
    logic [XLEN-1:0]  trap_vector;
    logic             if_stall;
    logic             id_stall;
    logic             exe_stall;
    logic             id_flush;
    logic             exe_bubble;
    logic             mdu_abort;
    logic             mdu_timeout;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_valid, exe_rd, exe_rd_wen, exe_mem_re, exe_jmp_taken,
               exe_jmp_target, mdu_start, mdu_done, mem_busy, trap_req,
               trap_vector,
        input  if_stall, id_stall, exe_stall, id_flush, exe_bubble,
               mdu_abort, mdu_timeout, redirect_valid, redirect_pc,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_valid, exe_rd, exe_rd_wen, exe_mem_re, exe_jmp_taken,
               exe_jmp_target, mdu_start, mdu_done, mem_busy, trap_req,
               trap_vector,
        output if_stall, id_stall, exe_stall, id_flush, exe_bubble,
               mdu_abort, mdu_timeout, redirect_valid, redirect_pc,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID/EXE hazard sequencer: stall/flush/bubble generation, registered PC
// redirect, MDU watchdog and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int MW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [MW-1:0] LIMIT = MW'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, REDIRECT, MDU_WAIT} state_t;

    state_t        state;
    logic [MW-1:0] cnt;
    logic          load_use;
    logic          at_limit;
    logic          jump_acc;
    logic          mdu_acc;
    logic          mdu_end;

    always_comb begin
        bus.if_stall    = 1'b0;
        bus.id_stall    = 1'b0;
        bus.exe_stall   = 1'b0;
        bus.id_flush    = 1'b0;
        bus.exe_bubble  = 1'b0;
        bus.mdu_abort   = 1'b0;
        bus.mdu_timeout = 1'b0;
        jump_acc        = 1'b0;
        mdu_acc         = 1'b0;
        mdu_end         = 1'b0;
        at_limit        = (cnt == LIMIT);
        load_use = bus.exe_valid && bus.exe_mem_re && bus.exe_rd_wen &&
                   (bus.exe_rd != 5'd0) && bus.id_valid &&
                   ((bus.id_rs1_used && bus.id_rs1 == bus.exe_rd) ||
                    (bus.id_rs2_used && bus.id_rs2 == bus.exe_rd));
        // Controls are forced low while reset is asserted, whatever the inputs.
        if (!rst_n) begin
            jump_acc = 1'b0;
        end else if (bus.trap_req) begin
            bus.id_flush   = 1'b1;
            bus.exe_bubble = 1'b1;
            bus.mdu_abort  = (state == MDU_WAIT) && !bus.mdu_done;
        end else if (bus.mem_busy) begin
            bus.if_stall  = 1'b1;
            bus.id_stall  = 1'b1;
            bus.exe_stall = 1'b1;
            if (state == REDIRECT) begin
                bus.id_flush   = 1'b1;
                bus.exe_bubble = 1'b1;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.exe_valid && bus.exe_jmp_taken) begin
                        bus.id_flush   = 1'b1;
                        bus.exe_bubble = 1'b1;
                        jump_acc       = 1'b1;
                    end else if (bus.exe_valid && bus.mdu_start) begin
                        mdu_acc = 1'b1;
                    end else if (load_use) begin
                        bus.if_stall   = 1'b1;
                        bus.id_stall   = 1'b1;
                        bus.exe_bubble = 1'b1;
                    end
                end
                REDIRECT: begin
                    bus.id_flush   = 1'b1;
                    bus.exe_bubble = 1'b1;
                end
                MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        mdu_end = 1'b1;
                    end else if (at_limit) begin
                        bus.mdu_timeout = 1'b1;
                        bus.mdu_abort   = 1'b1;
                        mdu_end         = 1'b1;
                    end else begin
                        bus.if_stall  = 1'b1;
                        bus.id_stall  = 1'b1;
                        bus.exe_stall = 1'b1;
                    end
                end
                default: jump_acc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= RUN;
            cnt                <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.stall_cnt      <= '0;
            bus.flush_cnt      <= '0;
        end else begin
            if (bus.if_stall && bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 1'b1;

            if (bus.trap_req) begin
                state              <= REDIRECT;
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= bus.trap_vector;
                if (bus.flush_cnt != '1)
                    bus.flush_cnt <= bus.flush_cnt + 1'b1;
            end else if (bus.mem_busy) begin
                // Watchdog keeps running but parks at its limit so it fires once released.
                if (state == MDU_WAIT && !at_limit)
                    cnt <= cnt + 1'b1;
            end else begin
                bus.redirect_valid <= 1'b0;
                unique case (state)
                    RUN: begin
                        if (jump_acc) begin
                            state              <= REDIRECT;
                            bus.redirect_valid <= 1'b1;
                            bus.redirect_pc    <= bus.exe_jmp_target;
                            if (bus.flush_cnt != '1)
                                bus.flush_cnt <= bus.flush_cnt + 1'b1;
                        end else if (mdu_acc) begin
                            state <= MDU_WAIT;
                            cnt   <= '0;
                        end
                    end
                    REDIRECT: state <= RUN;
                    MDU_WAIT: begin
                        if (mdu_end) state <= RUN;
                        else         cnt   <= cnt + 1'b1;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle control table from RUN,
// then multi-cycle jump, MDU, back-pressure, trap and reset sequences.
module tb_pipe_hazard_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.XLEN(XLEN), .MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic       exe_valid;
        logic [4:0] rd;
        logic       rd_wen;
        logic       mem_re;
        logic       jmp;
        logic       busy;
        logic       trap;
        logic [4:0] exp;   // {if_stall, id_stall, exe_stall, id_flush, exe_bubble}
    } vec_t;

    vec_t vecs[12];

    function automatic logic [4:0] ctl();
        return {bus.if_stall, bus.id_stall, bus.exe_stall, bus.id_flush, bus.exe_bubble};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.exe_valid = 0; bus.exe_rd = 0; bus.exe_rd_wen = 0; bus.exe_mem_re = 0;
        bus.exe_jmp_taken = 0; bus.exe_jmp_target = '0;
        bus.mdu_start = 0; bus.mdu_done = 0; bus.mem_busy = 0;
        bus.trap_req = 0; bus.trap_vector = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{"lu_rs1",      1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 5'b11001};
        vecs[1]  = '{"lu_x0",       1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 5'b00000};
        vecs[2]  = '{"lu_rs2",      1, 3, 7, 1, 1, 1, 7, 1, 1, 0, 0, 0, 5'b11001};
        vecs[3]  = '{"rs1_unused",  1, 5, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, 5'b00000};
        vecs[4]  = '{"no_load",     1, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 5'b00000};
        vecs[5]  = '{"exe_invalid", 1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 5'b00000};
        vecs[6]  = '{"id_invalid",  0, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 5'b00000};
        vecs[7]  = '{"no_wen",      1, 5, 0, 1, 0, 1, 5, 0, 1, 0, 0, 0, 5'b00000};
        vecs[8]  = '{"jmp_and_lu",  1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 0, 0, 5'b00011};
        vecs[9]  = '{"busy_lu",     1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 1, 0, 5'b11100};
        vecs[10] = '{"trap_busy",   1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 1, 1, 5'b00011};
        vecs[11] = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000};

        reset_dut();
        check("rst_ctl", ctl(), 5'b0);
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_flush_cnt", bus.flush_cnt, 0);

        // Table: each vector applied from a freshly reset RUN state, checked before any edge.
        for (int i = 0; i < 12; i++) begin
            step();
            idle();
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
            bus.id_valid = vecs[i].id_valid; bus.id_rs1 = vecs[i].rs1; bus.id_rs2 = vecs[i].rs2;
            bus.id_rs1_used = vecs[i].rs1_used; bus.id_rs2_used = vecs[i].rs2_used;
            bus.exe_valid = vecs[i].exe_valid; bus.exe_rd = vecs[i].rd;
            bus.exe_rd_wen = vecs[i].rd_wen; bus.exe_mem_re = vecs[i].mem_re;
            bus.exe_jmp_taken = vecs[i].jmp; bus.mem_busy = vecs[i].busy;
            bus.trap_req = vecs[i].trap;
            #2;
            check(vecs[i].name, ctl(), vecs[i].exp);
        end

        // Load-use lasts one cycle: EXE holds a bubble afterwards.
        reset_dut();
        step();
        bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1;
        bus.exe_valid = 1; bus.exe_rd = 5; bus.exe_rd_wen = 1; bus.exe_mem_re = 1;
        @(negedge clk) check("lu_cycle0", ctl(), 5'b11001);
        step();
        bus.exe_valid = 0;
        @(negedge clk) check("lu_cycle1", ctl(), 5'b00000);
        step();
        check("lu_stall_cnt", bus.stall_cnt, 1);

        // Taken jump.
        reset_dut();
        step();
        bus.exe_valid = 1; bus.exe_jmp_taken = 1; bus.exe_jmp_target = 32'h8000_0040;
        @(negedge clk);
        check("jmp_T_ctl", ctl(), 5'b00011);
        check("jmp_T_rv", bus.redirect_valid, 0);
        step();
        idle();
        @(negedge clk);
        check("jmp_T1_ctl", ctl(), 5'b00011);
        check("jmp_T1_rv", bus.redirect_valid, 1);
        check("jmp_T1_pc", bus.redirect_pc, 64'h8000_0040);
        step();
        @(negedge clk);
        check("jmp_T2_ctl", ctl(), 5'b00000);
        check("jmp_T2_rv", bus.redirect_valid, 0);
        check("jmp_flush_cnt", bus.flush_cnt, 1);

        // MDU completes after 5 wait cycles.
        begin
            int stalls = 0;
            reset_dut();
            step();
            bus.exe_valid = 1; bus.mdu_start = 1;
            @(negedge clk) check("mdu_start_stall", bus.exe_stall, 0);
            step();
            idle();
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (bus.exe_stall) stalls++;
                step();
            end
            check("mdu_wait_stalls", stalls, 5);
            bus.mdu_done = 1;
            @(negedge clk) check("mdu_done_ctl", ctl(), 5'b00000);
            step();
            idle();
            @(negedge clk) check("mdu_after_done", bus.exe_stall, 0);
            check("mdu_stall_cnt", bus.stall_cnt, 5);
        end

        // MDU watchdog with MDU_TIMEOUT=8.
        reset_dut();
        step();
        bus.exe_valid = 1; bus.mdu_start = 1;
        step();
        idle();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check("tmo_wait_stall", bus.exe_stall, 1);
            check("tmo_wait_pulse", {bus.mdu_timeout, bus.mdu_abort}, 2'b00);
            step();
        end
        @(negedge clk);
        check("tmo_pulse", {bus.mdu_timeout, bus.mdu_abort}, 2'b11);
        check("tmo_release", bus.exe_stall, 0);
        step();
        @(negedge clk);
        check("tmo_after", {bus.mdu_timeout, bus.mdu_abort, bus.exe_stall}, 3'b000);
        check("tmo_stall_cnt", bus.stall_cnt, 7);

        // Jump held off by mem_busy for 3 cycles.
        reset_dut();
        step();
        bus.exe_valid = 1; bus.exe_jmp_taken = 1; bus.exe_jmp_target = 32'h0000_2000;
        bus.mem_busy = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("busy_ctl", ctl(), 5'b11100);
            check("busy_rv", bus.redirect_valid, 0);
            step();
        end
        bus.mem_busy = 0;
        @(negedge clk) check("busy_release_ctl", ctl(), 5'b00011);
        step();
        idle();
        @(negedge clk);
        check("busy_rv_after", bus.redirect_valid, 1);
        check("busy_pc_after", bus.redirect_pc, 64'h2000);
        check("busy_stall_cnt", bus.stall_cnt, 3);
        check("busy_flush_cnt", bus.flush_cnt, 1);

        // Trap during MDU_WAIT aborts the MDU.
        reset_dut();
        step();
        bus.exe_valid = 1; bus.mdu_start = 1;
        step();
        idle();
        step();
        bus.trap_req = 1; bus.trap_vector = 32'h0000_0100;
        @(negedge clk);
        check("trap_abort", bus.mdu_abort, 1);
        check("trap_ctl", ctl(), 5'b00011);
        step();
        idle();
        @(negedge clk);
        check("trap_rv", bus.redirect_valid, 1);
        check("trap_pc", bus.redirect_pc, 64'h100);
        check("trap_abort_gone", bus.mdu_abort, 0);
        step();

        // Trap coinciding with mdu_done: no abort pulse.
        bus.exe_valid = 1; bus.mdu_start = 1;
        step();
        idle();
        bus.mdu_done = 1; bus.trap_req = 1; bus.trap_vector = 32'h0000_0200;
        @(negedge clk) check("trap_done_abort", bus.mdu_abort, 0);
        step();
        idle();
        @(negedge clk) check("trap_done_pc", bus.redirect_pc, 64'h200);
        check("trap_flush_cnt", bus.flush_cnt, 2);
        step();

        // Reset in the middle of an MDU wait.
        bus.exe_valid = 1; bus.mdu_start = 1;
        step();
        idle();
        @(negedge clk) check("rstmid_wait", bus.exe_stall, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_ctl", ctl(), 5'b0);
        check("rstmid_pulses", {bus.mdu_abort, bus.mdu_timeout, bus.redirect_valid}, 3'b000);
        check("rstmid_pc", bus.redirect_pc, 0);
        check("rstmid_cnts", {bus.stall_cnt, bus.flush_cnt}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk) check("rstmid_run", bus.exe_stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
